sap1_output_display: RTL and testbench

//  Downstream consumer of the SAP-1 output register. It captures each new 8-bit OUT value and converts
//  it to 3-digit BCD with a sequential double-dabble (one shift per clock). The result is driven onto a

---
 rtl/sap1_output_display.sv | 185 ++++++++++++++++++
 tb/tb_sap1_output_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_output_display.sv
// sap1_output_display
//   Captures each value written to the SAP-1 output register, converts it to
//   three BCD digits with a sequential double-dabble (one shift per clock) and
//   drives a time-multiplexed three-digit seven-segment display.
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      1-cycle strobe, data_in valid
//   data_in   8-bit unsigned value
//   bcd       last completed conversion {hundreds,tens,ones}
//   busy      conversion in progress
//   done      1-cycle pulse when bcd updates
//   seg       segments {g,f,e,d,c,b,a} of the enabled digit
//   digit_en  one-hot digit enable: [0]=ones, [1]=tens, [2]=hundreds
module sap1_output_display #(
  parameter int unsigned REFRESH_DIV  = 10000,
  parameter bit          COMMON_ANODE = 1'b0,
  parameter bit          BLANK_LEAD   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  data_in,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic [2:0]  digit_en
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [19:0]     shift_q, shift_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_val_q, pend_val_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [RW-1:0]   refresh_q, refresh_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      den_q, den_d;

  logic            blank_h, blank_t;

  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh load wins over a pending value, which is then dropped.
        if (load) begin
          shift_d = {12'h000, data_in};
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = SHIFT;
        end else if (pend_q) begin
          shift_d = {12'h000, pend_val_q};
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = dd_step(shift_q);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d   = shift_q[19:8];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = data_in;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // Decoded from the next-cycle bcd and index so the registered outputs
    // always match bcd_q and both change on the same edge.
    blank_h = BLANK_LEAD && (bcd_d[11:8] == 4'd0);
    blank_t = blank_h && (bcd_d[7:4] == 4'd0);
    seg_d   = '0;
    den_d   = '0;
    case (idx_d)
      2'd0: begin
        den_d = 3'b001;
        seg_d = seg_decode(bcd_d[3:0]);
      end
      2'd1: begin
        den_d = 3'b010;
        seg_d = blank_t ? 7'b0000000 : seg_decode(bcd_d[7:4]);
      end
      2'd2: begin
        den_d = 3'b100;
        seg_d = blank_h ? 7'b0000000 : seg_decode(bcd_d[11:8]);
      end
      default: begin
        den_d = '0;
        seg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
      refresh_q  <= '0;
      idx_q      <= '0;
      seg_q      <= 7'b0111111;
      den_q      <= 3'b001;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      den_q      <= den_d;
    end
  end

  assign bcd      = bcd_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign seg      = COMMON_ANODE ? ~seg_q : seg_q;
  assign digit_en = COMMON_ANODE ? ~den_q : den_q;

endmodule

// File: tb/tb_sap1_output_display.sv
// Testbench for sap1_output_display. Two instances share stimulus:
//   dut_a: REFRESH_DIV=2, active-high, leading-zero blanking
//   dut_b: REFRESH_DIV=4, common anode, no blanking
module tb_sap1_output_display;

  typedef struct {
    int unsigned val;
    int unsigned edge_n;
  } exp_t;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic [11:0] bcd_a, bcd_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  den_a, den_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned disp_val[2];
  bit          cur_valid = 1'b0;
  int unsigned cur_start = 0;
  bit          pend_valid = 1'b0;
  int unsigned pend_val = 0;

  always #5 clk = ~clk;

  sap1_output_display #(.REFRESH_DIV(2), .COMMON_ANODE(1'b0), .BLANK_LEAD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .bcd(bcd_a), .busy(busy_a), .done(done_a), .seg(seg_a), .digit_en(den_a)
  );

  sap1_output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b1), .BLANK_LEAD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .bcd(bcd_b), .busy(busy_b), .done(done_b), .seg(seg_b), .digit_en(den_b)
  );

  function automatic int unsigned to_bcd(input int unsigned v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic void exp_disp(input int unsigned v, input int unsigned idx,
                                   input bit bl, input bit ca,
                                   output logic [6:0] s, output logic [2:0] d);
    int unsigned h, t, o, dig;
    bit blank;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    dig = (idx == 0) ? o : (idx == 1) ? t : h;
    blank = bl && (((idx == 2) && (h == 0)) || ((idx == 1) && (h == 0) && (t == 0)));
    s = blank ? 7'h00 : SEG_TAB[dig];
    d = 3'(1 << idx);
    if (ca) begin
      s = ~s;
      d = ~d;
    end
  endfunction

  task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, w, cyc, act, exp);
    end
  endtask

  // Reference model: a converter is free 10 edges after it started; loads
  // during that window land in a last-wins pending slot.
  task automatic start_conv(input int unsigned v);
    exp_t e;
    cur_valid = 1'b1;
    cur_start = cyc;
    e.val = v;
    e.edge_n = cyc + 9;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  task automatic model_step(input bit l, input int unsigned d);
    if (!cur_valid || (cyc >= cur_start + 10)) begin
      if (l) begin
        start_conv(d);
        pend_valid = 1'b0;
      end else if (pend_valid) begin
        start_conv(pend_val);
        pend_valid = 1'b0;
      end
    end else if (l) begin
      pend_valid = 1'b1;
      pend_val = d;
    end
  endtask

  task automatic cycle(input bit l, input int unsigned d);
    @(negedge clk);
    load = l;
    data_in = 8'(d);
    @(posedge clk);
    cyc++;
    if (rst_n) model_step(l, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    cur_valid = 1'b0;
    pend_valid = 1'b0;
    disp_val[0] = 0;
    disp_val[1] = 0;
    idle(n);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic mon(input int w, input logic [11:0] b, input logic bz, input logic dn,
                     input logic [6:0] s, input logic [2:0] de);
    exp_t e;
    logic [6:0] es;
    logic [2:0] ed;
    int unsigned div, idx, qs;
    bit bl, ca, busy_exp;
    div = (w == 0) ? 2 : 4;
    bl  = (w == 0);
    ca  = (w == 1);
    if (!rst_n) begin
      chk("rst_bcd", w, 32'(b), 32'd0);
      chk("rst_busy", w, 32'(bz), 32'd0);
      chk("rst_done", w, 32'(dn), 32'd0);
      exp_disp(0, 0, bl, ca, es, ed);
      chk("rst_seg", w, 32'(s), 32'(es));
      chk("rst_digit_en", w, 32'(de), 32'(ed));
      return;
    end
    qs = (w == 0) ? q_a.size() : q_b.size();
    if (dn) begin
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut%0d cycle %0d: got done=1, expected no pulse", w, cyc);
      end else begin
        e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        chk("done_cycle", w, e.edge_n, cyc);
        chk("bcd_result", w, 32'(b), to_bcd(e.val));
        disp_val[w] = e.val;
      end
    end else if (qs != 0) begin
      e = (w == 0) ? q_a[0] : q_b[0];
      if (e.edge_n < cyc) begin
        checks++;
        errors++;
        $display("FAIL done_timeout dut%0d cycle %0d: got no done, expected done at cycle %0d", w, cyc, e.edge_n);
        if (w == 0) void'(q_a.pop_front());
        else void'(q_b.pop_front());
      end
    end
    chk("bcd_hold", w, 32'(b), to_bcd(disp_val[w]));
    busy_exp = cur_valid && ((cyc - cur_start) <= 8);
    chk("busy", w, 32'(bz), 32'(busy_exp));
    idx = ((cyc - rel_cyc) / div) % 3;
    exp_disp(disp_val[w], idx, bl, ca, es, ed);
    chk("seg", w, 32'(s), 32'(es));
    chk("digit_en", w, 32'(de), 32'(ed));
  endtask

  always @(negedge clk) begin
    mon(0, bcd_a, busy_a, done_a, seg_a, den_a);
    mon(1, bcd_b, busy_b, done_b, seg_b, den_b);
  end

  initial begin
    disp_val[0] = 0;
    disp_val[1] = 0;
    do_reset(3);
    idle(14);

    cycle(1'b1, 255);
    idle(24);

    cycle(1'b1, 7);
    idle(2);
    cycle(1'b1, 200);
    cycle(1'b1, 42);
    idle(28);

    cycle(1'b1, 100);
    idle(16);
    cycle(1'b1, 5);
    idle(16);
    cycle(1'b1, 0);
    idle(16);

    cycle(1'b1, 99);
    idle(3);
    do_reset(2);
    idle(4);
    cycle(1'b1, 123);
    idle(16);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 255));
    end
    idle(24);

    chk("queue_a_empty", 0, q_a.size(), 32'd0);
    chk("queue_b_empty", 1, q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
